// File: rtl/enc_binder_stream.sv
`default_nettype none
// ============================================================================
// Module      : enc_binder_stream
// Description : Streams LANES level hypervectors per beat and binds each one by
//               rotating it left by its feature's shift amount. The result goes
//               out through one registered valid/ready stage.
//               Optional macro ENC_BINDER_SHIFT_CFG_EN makes the shift table
//               writable at run time.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_binder_stream #(
    parameter int HV_DIM       = 2048,
    parameter int LANES        = 4,
    parameter int FEATURES     = 32,
    parameter int SHIFT_STRIDE = 67,
    parameter int SHIFT_OFFSET = 13,
    localparam int SHIFT_W     = $clog2(HV_DIM),
    localparam int GROUPS      = FEATURES / LANES,
    localparam int GRP_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int ADDR_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic [LANES-1:0][HV_DIM-1:0]  level_hv,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0][HV_DIM-1:0]  shifted_hv,
    output logic [GRP_W-1:0]              out_grp,
    output logic                          out_last,
    output logic                          seq_err,
    input  logic                          cfg_we,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    output logic                          cfg_busy
);

    function automatic logic [SHIFT_W-1:0] default_shift(input int f);
        longint v;
        v = (longint'(f) * SHIFT_STRIDE + SHIFT_OFFSET) % HV_DIM;
        return SHIFT_W'(v);
    endfunction

    logic [SHIFT_W-1:0]             w_shift_tbl [FEATURES];
    logic [GRP_W-1:0]               r_grp_idx;
    logic [GRP_W-1:0]               w_grp;
    logic                           w_grp_last;
    logic                           w_accept;
    logic                           r_out_valid;
    logic [GRP_W-1:0]               r_out_grp;
    logic                           r_out_last;
    logic                           r_seq_err;
    logic [LANES-1:0][HV_DIM-1:0]   r_shifted;
    logic [LANES-1:0][HV_DIM-1:0]   w_rotated;

`ifdef ENC_BINDER_SHIFT_CFG_EN
    logic [SHIFT_W-1:0] r_shift_tbl [FEATURES];
    logic               w_cfg_busy;

    // Table may only change between samples, so a sample never mixes tables.
    assign w_cfg_busy = (r_grp_idx != '0) | r_out_valid | in_valid;
    assign cfg_busy   = w_cfg_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < FEATURES; f++) begin
                r_shift_tbl[f] <= default_shift(f);
            end
        end else if (cfg_we && !w_cfg_busy && (int'(cfg_addr) < FEATURES)) begin
            r_shift_tbl[cfg_addr] <= SHIFT_W'(int'(cfg_shift) % HV_DIM);
        end
    end

    for (genvar f = 0; f < FEATURES; f++) begin : g_tbl_reg
        assign w_shift_tbl[f] = r_shift_tbl[f];
    end
`else
    logic w_cfg_unused;

    assign cfg_busy     = 1'b1;
    assign w_cfg_unused = ^{cfg_we, cfg_addr, cfg_shift};

    for (genvar f = 0; f < FEATURES; f++) begin : g_tbl_const
        localparam logic [SHIFT_W-1:0] c_shift = default_shift(f);
        assign w_shift_tbl[f] = c_shift;
    end
`endif

    assign w_grp      = in_first ? '0 : r_grp_idx;
    assign w_grp_last = (w_grp == GRP_W'(GROUPS - 1));
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    // Left rotation by s: low half of {x,x} >> (HV_DIM - s); s = 0 passes x through.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ADDR_W-1:0]  w_feat;
        logic [SHIFT_W-1:0] w_s;

        assign w_feat       = ADDR_W'(int'(w_grp) * LANES + l);
        assign w_s          = w_shift_tbl[w_feat];
        assign w_rotated[l] = HV_DIM'({level_hv[l], level_hv[l]} >> (HV_DIM - int'(w_s)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_grp   <= '0;
            r_out_last  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_shifted   <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_shifted   <= w_rotated;
                r_out_grp   <= w_grp;
                r_out_last  <= w_grp_last;
                r_grp_idx   <= w_grp_last ? '0 : w_grp + GRP_W'(1);
                if (in_first && (r_grp_idx != '0)) begin
                    r_seq_err <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_grp    = r_out_grp;
    assign out_last   = r_out_last;
    assign seq_err    = r_seq_err;
    assign shifted_hv = r_shifted;

endmodule
`default_nettype wire

// File: tb/tb_enc_binder_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_binder_stream
// Description : Directed self-checking bench for enc_binder_stream (default
//               parameters); also covers ENC_BINDER_SHIFT_CFG_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_binder_stream;

    localparam int HV_DIM   = 2048;
    localparam int LANES    = 4;
    localparam int FEATURES = 32;
    localparam int GROUPS   = 8;
    localparam int GRP_W    = 3;
    localparam int ADDR_W   = 5;
    localparam int SHIFT_W  = 11;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_first;
    logic [LANES-1:0][HV_DIM-1:0]  level_hv;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0][HV_DIM-1:0]  shifted_hv;
    logic [GRP_W-1:0]              out_grp;
    logic                          out_last;
    logic                          seq_err;
    logic                          cfg_we;
    logic [ADDR_W-1:0]             cfg_addr;
    logic [SHIFT_W-1:0]            cfg_shift;
    logic                          cfg_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    enc_binder_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .level_hv   (level_hv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .shifted_hv (shifted_hv),
        .out_grp    (out_grp),
        .out_last   (out_last),
        .seq_err    (seq_err),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_shift  (cfg_shift),
        .cfg_busy   (cfg_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int first_one(input logic [HV_DIM-1:0] v);
        for (int i = 0; i < HV_DIM; i++) begin
            if (v[i]) return i;
        end
        return HV_DIM;
    endfunction

    function automatic int exp_pos(input int f);
        return (f * 67 + 13) % HV_DIM;
    endfunction

    // Present one beat, wait for acceptance, then check the registered output.
    task automatic send_beat(input logic first, input logic [HV_DIM-1:0] hv,
                             input int exp_grp, input bit onehot);
        bit acc;
        in_valid = 1'b1;
        in_first = first;
        for (int l = 0; l < LANES; l++) level_hv[l] = hv;
        acc = 1'b0;
        for (int w = 0; w < 20 && !acc; w++) begin
            #1 acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_first = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        check($sformatf("g%0d_valid", exp_grp), out_valid, 1);
        check($sformatf("g%0d_grp", exp_grp), out_grp, exp_grp);
        check($sformatf("g%0d_last", exp_grp), out_last, (exp_grp == GROUPS - 1));
        if (onehot) begin
            for (int l = 0; l < LANES; l++) begin
                check($sformatf("g%0d_l%0d_pos", exp_grp, l), first_one(shifted_hv[l]),
                      exp_pos(exp_grp * LANES + l));
                check($sformatf("g%0d_l%0d_cnt", exp_grp, l), $countones(shifted_hv[l]), 1);
            end
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [HV_DIM-1:0] hv_one;
    logic [HV_DIM-1:0] hv_edge;

    initial begin
        hv_one            = '0;
        hv_one[0]         = 1'b1;
        hv_edge           = hv_one;
        hv_edge[HV_DIM-1] = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        level_hv  = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_shift = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_grp", out_grp, 0);
        check("rst_last", out_last, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_hv", $countones(shifted_hv), 0);
        rst_n = 1'b1;

        // Full-rate sample, one-hot input.
        for (int g = 0; g < GROUPS; g++) send_beat(g == 0, hv_one, g, 1);
        check("f31_pos_literal", first_one(shifted_hv[3]), 42);
        idle_cycle();
        check("drain_valid", out_valid, 0);

        // Back-pressure while beat 3 sits in the output register.
        for (int g = 0; g < 4; g++) send_beat(g == 0, hv_one, g, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_grp", out_grp, 3);
            check("stall_pos", first_one(shifted_hv[0]), 817);
        end
        out_ready = 1'b1;
        for (int g = 4; g < GROUPS; g++) send_beat(1'b0, hv_one, g, 1);
        idle_cycle();

        // Resync: in_first at group 0 is normal, at group 5 is an error.
        send_beat(1'b1, hv_one, 0, 1);
        check("first_ok_seq_err", seq_err, 0);
        for (int g = 1; g < 5; g++) send_beat(1'b0, hv_one, g, 0);
        send_beat(1'b1, hv_one, 0, 1);
        check("resync_seq_err", seq_err, 1);
        for (int g = 1; g < 4; g++) send_beat(1'b0, hv_one, g, 0);
        check("seq_err_sticky", seq_err, 1);

        // Reset with a group-3 beat in flight.
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_seq_err", seq_err, 0);
        check("mid_rst_grp", out_grp, 0);
        send_beat(1'b0, hv_one, 0, 1);
        idle_cycle();

        // Table write while mid-sample must be ignored.
        check("busy_mid_sample", cfg_busy, 1);
        cfg_we    = 1'b1;
        cfg_addr  = 5'd2;
        cfg_shift = '0;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        for (int g = 1; g < GROUPS; g++) send_beat(1'b0, hv_one, g, 0);
        send_beat(1'b1, hv_one, 0, 1);
        check("busy_write_ignored", first_one(shifted_hv[2]), 147);
        for (int g = 1; g < GROUPS; g++) send_beat(1'b0, hv_one, g, 0);
        idle_cycle();

        // Idle write of shift 0 to feature 2.
`ifdef ENC_BINDER_SHIFT_CFG_EN
        check("busy_idle", cfg_busy, 0);
`else
        check("busy_idle", cfg_busy, 1);
`endif
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        send_beat(1'b1, hv_edge, 0, 0);
        check("edge_l0_pos", first_one(shifted_hv[0]), 12);
        check("edge_l0_cnt", $countones(shifted_hv[0]), 2);
        check("edge_l2_cnt", $countones(shifted_hv[2]), 2);
`ifdef ENC_BINDER_SHIFT_CFG_EN
        check("edge_l2_pos", first_one(shifted_hv[2]), 0);
        check("edge_l2_msb", shifted_hv[2][HV_DIM-1], 1);
`else
        check("edge_l2_pos", first_one(shifted_hv[2]), 146);
        check("edge_l2_b147", shifted_hv[2][147], 1);
`endif
        idle_cycle();
        check("end_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
